bcd_counter_nd: RTL and testbench

Parametrised synchronous multi-digit decade counter, the clocked successor to the team's asynchronous 7490-style mod-2/mod-5 counter. It holds DIGITS cascaded digits of modulus MOD (default 10, i.e. BCD) and counts up or down. It supports clear-to-0 and preset-to-max (7490 MR/MS equivalents), parallel load with range clamping, and cascade carry. It also provides a registered even/odd flag for the Even/Odd BCD counter datapath.

---
 rtl/bcd_counter_nd.sv | 154 +++++++++++++++
 tb/tb_bcd_counter_nd.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bcd_counter_nd.sv
// bcd_counter_nd: synchronous DIGITS-digit up/down counter, every digit modulo MOD.
// Provides clear, preset-to-max, clamped parallel load, cascade carry (tc) and
// registered odd/even flags. Legal ranges: DIGITS 1..8, MOD 2..16.

// One digit: next-value selection for a single 4-bit digit.
module bcd_digit_cell #(
    parameter int MOD = 10
) (
    input  logic [3:0] q,        // current digit value
    input  logic [3:0] d,        // parallel load value for this digit
    input  logic       do_clr,   // decoded actions; at most one is set
    input  logic       do_set,
    input  logic       do_load,
    input  logic       do_step,  // count this digit (lower digits allow it)
    input  logic       up,
    output logic [3:0] nxt,
    output logic       clamped,  // load value was out of range
    output logic       at_max,
    output logic       at_zero
);
    localparam logic [3:0] MAXV = 4'(MOD - 1);

    logic [3:0] inc_v;
    logic [3:0] dec_v;
    logic [3:0] ld_v;

    // Wrapping step values, clamped load value and the selected next value.
    // An out-of-range digit steps modulo 16 until it re-enters range.
    always_comb begin
        at_max  = (q == MAXV);
        at_zero = (q == 4'd0);
        inc_v   = at_max  ? 4'd0 : q + 4'd1;
        dec_v   = at_zero ? MAXV : q - 4'd1;
        // compare in 5 bits so MOD=16 does not turn into a constant compare
        clamped = ({1'b0, d} >= 5'(MOD));
        ld_v    = clamped ? MAXV : d;
        nxt     = q;
        if (do_clr)
            nxt = 4'd0;
        else if (do_set)
            nxt = MAXV;
        else if (do_load)
            nxt = ld_v;
        else if (do_step)
            nxt = up ? inc_v : dec_v;
    end
endmodule

// Top level: priority decode, ripple enable chain across digits, registers.
module bcd_counter_nd #(
    parameter int DIGITS = 4,
    parameter int MOD    = 10
) (
    input  logic                  CP,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  set9,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   D,
    input  logic                  en,
    input  logic                  cin,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  tc,
    output logic                  odd,
    output logic                  even,
    output logic                  ld_err
);
    typedef struct packed {
        logic clr;
        logic set;
        logic load;
        logic cnt;
    } act_t;

    act_t                    act;
    logic [DIGITS-1:0][3:0]  q_q;
    logic [DIGITS-1:0][3:0]  q_d;
    logic [DIGITS-1:0][3:0]  d_dig;
    logic [DIGITS-1:0]       step;
    logic [DIGITS-1:0]       clamped;
    logic [DIGITS-1:0]       at_max;
    logic [DIGITS-1:0]       at_zero;
    logic                    odd_q;
    logic                    odd_d;
    logic                    even_q;
    logic                    even_d;
    logic                    ld_err_q;
    logic                    ld_err_d;

    assign d_dig = D;

    // Priority decode: clear over preset over load over count; reset is in the flop.
    always_comb begin
        act      = '0;
        act.clr  = clr;
        act.set  = ~clr & set9;
        act.load = ~clr & ~set9 & load;
        act.cnt  = ~clr & ~set9 & ~load & en & cin;
    end

    // Digit k steps when every lower digit sits at the wrap point for the direction.
    always_comb begin
        step    = '0;
        step[0] = act.cnt;
        for (int k = 1; k < DIGITS; k++)
            step[k] = step[k-1] & (up ? at_max[k-1] : at_zero[k-1]);
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        bcd_digit_cell #(.MOD(MOD)) u_cell (
            .q       (q_q[k]),
            .d       (d_dig[k]),
            .do_clr  (act.clr),
            .do_set  (act.set),
            .do_load (act.load),
            .do_step (step[k]),
            .up      (up),
            .nxt     (q_d[k]),
            .clamped (clamped[k]),
            .at_max  (at_max[k]),
            .at_zero (at_zero[k])
        );
    end

    // Parity flags track the next count; ld_err pulses only on a clamped load.
    always_comb begin
        odd_d    = q_d[0][0];
        even_d   = ~q_d[0][0];
        ld_err_d = act.load & (|clamped);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge CP) begin
        if (!rst) begin
            q_q      <= '0;
            odd_q    <= 1'b0;
            even_q   <= 1'b1;
            ld_err_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            odd_q    <= odd_d;
            even_q   <= even_d;
            ld_err_q <= ld_err_d;
        end
    end

    // Cascade carry out: deliberately not gated by reset/clear/preset/load.
    assign tc     = en & cin & (up ? (&at_max) : (&at_zero));
    assign Q      = q_q;
    assign odd    = odd_q;
    assign even   = even_q;
    assign ld_err = ld_err_q;
endmodule

// File: tb/tb_bcd_counter_nd.sv
// Scoreboard bench for bcd_counter_nd: the driver pushes hand-computed
// expectations after each edge; a negedge monitor pops and compares them.
module tb_bcd_counter_nd;
    logic        CP = 1'b0;
    logic        rst, clr, set9, load, en, cin, up;
    logic [15:0] D;

    logic [15:0] q4;  logic tc4, odd4, even4, err4;
    logic [7:0]  q2;  logic tc2, odd2, even2, err2;
    logic [11:0] q3;  logic tc3, odd3, even3, err3;
    logic [3:0]  qc0, qc1;
    logic        tcc0, tcc1, oddc0, evenc0, errc0, oddc1, evenc1, errc1;

    always #5 CP = ~CP;

    bcd_counter_nd #(.DIGITS(4), .MOD(10)) u4 (.CP(CP), .rst(rst), .clr(clr), .set9(set9),
        .load(load), .D(D), .en(en), .cin(cin), .up(up), .Q(q4), .tc(tc4), .odd(odd4),
        .even(even4), .ld_err(err4));
    bcd_counter_nd #(.DIGITS(2), .MOD(10)) u2 (.CP(CP), .rst(rst), .clr(clr), .set9(set9),
        .load(load), .D(D[7:0]), .en(en), .cin(cin), .up(up), .Q(q2), .tc(tc2), .odd(odd2),
        .even(even2), .ld_err(err2));
    bcd_counter_nd #(.DIGITS(3), .MOD(6)) u3 (.CP(CP), .rst(rst), .clr(clr), .set9(set9),
        .load(load), .D(D[11:0]), .en(en), .cin(cin), .up(up), .Q(q3), .tc(tc3), .odd(odd3),
        .even(even3), .ld_err(err3));
    // two single-digit stages cascaded tc -> cin must behave like u2
    bcd_counter_nd #(.DIGITS(1), .MOD(10)) c0 (.CP(CP), .rst(rst), .clr(clr), .set9(set9),
        .load(load), .D(D[3:0]), .en(en), .cin(cin), .up(up), .Q(qc0), .tc(tcc0), .odd(oddc0),
        .even(evenc0), .ld_err(errc0));
    bcd_counter_nd #(.DIGITS(1), .MOD(10)) c1 (.CP(CP), .rst(rst), .clr(clr), .set9(set9),
        .load(load), .D(D[7:4]), .en(en), .cin(tcc0), .up(up), .Q(qc1), .tc(tcc1), .odd(oddc1),
        .even(evenc1), .ld_err(errc1));

    typedef struct {
        int          sel;
        logic [15:0] q;
        logic        tc;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // monitor: compare every expectation pushed since the last falling edge
    always @(negedge CP) begin
        exp_t        e;
        logic [15:0] aq;
        logic        atc, aod, aev, aer;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            aq = '0; atc = 1'b0; aod = 1'b0; aev = 1'b0; aer = 1'b0;
            case (e.sel)
                2: begin aq = {8'h0, q2}; atc = tc2; aod = odd2; aev = even2; aer = err2; end
                3: begin aq = {4'h0, q3}; atc = tc3; aod = odd3; aev = even3; aer = err3; end
                default: begin aq = q4; atc = tc4; aod = odd4; aev = even4; aer = err4; end
            endcase
            chk($sformatf("u%0d.Q", e.sel), aq, e.q);
            chk($sformatf("u%0d.tc", e.sel), {15'h0, atc}, {15'h0, e.tc});
            chk($sformatf("u%0d.odd", e.sel), {15'h0, aod}, {15'h0, e.q[0]});
            chk($sformatf("u%0d.even", e.sel), {15'h0, aev}, {15'h0, ~e.q[0]});
            chk($sformatf("u%0d.ld_err", e.sel), {15'h0, aer}, {15'h0, e.err});
            if (e.sel == 2) begin
                chk("chain.Q", {8'h0, qc1, qc0}, e.q);
                chk("chain.tc", {15'h0, tcc1}, {15'h0, e.tc});
            end
        end
    end

    task automatic setc(input logic c, input logic s, input logic l, input logic e,
                        input logic ci, input logic u, input logic [15:0] d);
        clr = c; set9 = s; load = l; en = e; cin = ci; up = u; D = d;
    endtask

    task automatic push(input int sel, input logic [15:0] q, input logic t, input logic er);
        sb.push_back(exp_t'{sel, q, t, er});
    endtask

    task automatic settle();
        @(negedge CP);
        #1;
    endtask

    task automatic step(input int sel, input logic [15:0] q, input logic t, input logic er);
        @(posedge CP);
        push(sel, q, t, er);
        settle();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v;
        rst = 1'b0;
        setc(0, 0, 0, 0, 0, 0, 16'h0);
        // reset held two cycles, then idle with en=0
        repeat (2) begin
            @(posedge CP); push(4, 16'h0, 0, 0); push(2, 16'h0, 0, 0); push(3, 16'h0, 0, 0); settle();
        end
        rst = 1'b1;
        repeat (5) begin
            @(posedge CP); push(4, 16'h0, 0, 0); push(2, 16'h0, 0, 0); push(3, 16'h0, 0, 0); settle();
        end

        // up count with carry into digit 1
        setc(0, 0, 1, 0, 0, 1, 16'h0097); step(2, 16'h97, 0, 0);
        setc(0, 0, 0, 1, 1, 1, 16'h0);
        step(2, 16'h98, 0, 0);
        step(2, 16'h99, 1, 0);
        step(2, 16'h00, 0, 0);

        // down wrap from zero
        setc(1, 0, 0, 1, 1, 0, 16'h0); step(2, 16'h00, 1, 0);
        clr = 1'b0;                    step(2, 16'h99, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            v = 99 - i;
            step(2, 16'((v / 10) * 16 + (v % 10)), 0, 0);
        end

        // clamped load, one-cycle ld_err, priority combinations
        setc(0, 0, 1, 0, 0, 1, 16'h00C5); step(2, 16'h95, 0, 1);
        load = 1'b0;                      step(2, 16'h95, 0, 0);
        setc(1, 1, 0, 0, 0, 1, 16'h0);    step(2, 16'h00, 0, 0);
        setc(0, 1, 1, 0, 0, 1, 16'h00C5); step(2, 16'h99, 0, 0);

        // hold via cin, then count, then reverse direction
        setc(0, 0, 1, 0, 0, 1, 16'h0042); step(2, 16'h42, 0, 0);
        setc(0, 0, 0, 1, 0, 1, 16'h0);
        repeat (4) step(2, 16'h42, 0, 0);
        cin = 1'b1;                       step(2, 16'h43, 0, 0);
        up = 1'b0;                        step(2, 16'h42, 0, 0);

        // three digits of modulus 6: 40 counts from zero is 104 in base 6
        setc(1, 0, 0, 0, 0, 1, 16'h0);    step(3, 16'h000, 0, 0);
        setc(0, 0, 0, 1, 1, 1, 16'h0);
        for (int n = 1; n <= 40; n++)
            step(3, 16'(((n / 36) << 8) | (((n / 6) % 6) << 4) | (n % 6)), 0, 0);

        // reset wins over a clamping load
        rst = 1'b0;
        setc(0, 0, 1, 1, 1, 1, 16'h0999);
        @(posedge CP); push(3, 16'h000, 0, 0); push(2, 16'h00, 0, 0); push(4, 16'h0000, 0, 0); settle();

        // full down wrap from all zero on every width
        rst = 1'b1;
        setc(0, 0, 0, 1, 1, 0, 16'h0);
        @(posedge CP); push(3, 16'h555, 0, 0); push(2, 16'h99, 0, 0); push(4, 16'h9999, 0, 0); settle();

        // preset to max then full up wrap
        setc(0, 1, 0, 1, 1, 1, 16'h0);
        @(posedge CP); push(3, 16'h555, 1, 0); push(2, 16'h99, 1, 0); push(4, 16'h9999, 1, 0); settle();
        set9 = 1'b0;
        @(posedge CP); push(3, 16'h000, 0, 0); push(2, 16'h00, 0, 0); push(4, 16'h0000, 0, 0); settle();

        setc(0, 0, 0, 0, 0, 1, 16'h0);
        repeat (2) @(negedge CP);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
